keypad_scan_reader: RTL and testbench

//  Reads a 4x4 matrix keypad by the same time-multiplexed strobing used for the
//  7-seg anode scan: one column driven low per dwell slot, rows sampled back.

---
 rtl/keypad_pkg.sv | 28 ++
 rtl/keypad_row_sync.sv | 31 +++
 rtl/keypad_scan_reader.sv | 147 ++++++++++++++
 tb/tb_keypad_scan_reader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared constants, event kind and key-index helpers for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_KEYS = 16;
    localparam int unsigned KEY_W    = 4;
    localparam logic [3:0]  COL_IDLE = 4'b1110;

    typedef enum logic {
        EVT_PRESS   = 1'b0,
        EVT_RELEASE = 1'b1
    } evt_kind_e;

    function automatic logic [KEY_W-1:0] key_index(input logic [1:0] col, input logic [1:0] row);
        return {col, row};
    endfunction

    function automatic logic [KEY_W-1:0] lowest_set(input logic [NUM_KEYS-1:0] v);
        logic [KEY_W-1:0] idx;
        idx = '0;
        for (int unsigned i = NUM_KEYS; i > 0; i--) begin
            if (v[KEY_W'(i - 1)]) idx = KEY_W'(i - 1);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous keypad row returns; idles high (pulled up).
module keypad_row_sync #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = d_in;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign q_out = sync2_q;

endmodule

// File: rtl/keypad_scan_reader.sv
// Column-strobed 4x4 keypad reader with frame debounce and valid/ready key events.
// Optional KEYPAD_RELEASE_EVT_EN: also emit an event when a reported key is released.
module keypad_scan_reader
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 65536,
    parameter int unsigned DEBOUNCE_CNT = 4
) (
    input  logic        clkin,
    input  logic        reset,
    output logic [3:0]  COL,
    input  logic [3:0]  ROW,
    output logic [3:0]  key_code,
    output logic        key_valid,
    input  logic        key_ready,
    output logic [15:0] key_map,
    output logic        key_release
);

    localparam int unsigned DWELL_W = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W   = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(DEBOUNCE_CNT - 1);

    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [1:0]          col_q, col_d;
    logic [NUM_KEYS-1:0] frame_q, frame_d;
    logic [NUM_KEYS-1:0] prev_q, prev_d;
    logic [CNT_W-1:0]    stable_cnt_q, stable_cnt_d;
    logic [NUM_KEYS-1:0] key_map_q, key_map_d;
    logic [NUM_KEYS-1:0] reported_q, reported_d;
    logic [KEY_W-1:0]    code_q, code_d;
    logic                valid_q, valid_d;
    logic [NUM_ROWS-1:0] row_sync;
    logic [NUM_KEYS-1:0] press_cand;
    logic                sample;
    logic                slot_free;
`ifdef KEYPAD_RELEASE_EVT_EN
    logic [NUM_KEYS-1:0] rel_pend_q, rel_pend_d;
    evt_kind_e           kind_q, kind_d;
`endif

    keypad_row_sync #(.WIDTH(NUM_ROWS)) u_row_sync (
        .clk   (clkin),
        .reset (reset),
        .d_in  (ROW),
        .q_out (row_sync)
    );

    always_comb begin
        dwell_d      = dwell_q;
        col_d        = col_q;
        frame_d      = frame_q;
        prev_d       = prev_q;
        stable_cnt_d = stable_cnt_q;
        key_map_d    = key_map_q;
        reported_d   = reported_q & key_map_q;
        code_d       = code_q;
        valid_d      = valid_q;
        press_cand   = key_map_q & ~reported_q;
        sample       = (dwell_q == DWELL_LAST);
        slot_free    = !valid_q || key_ready;
`ifdef KEYPAD_RELEASE_EVT_EN
        kind_d       = kind_q;
        rel_pend_d   = rel_pend_q | (reported_q & ~key_map_q);
`endif

        dwell_d = sample ? '0 : dwell_q + 1'b1;
        if (sample) begin
            col_d = col_q + 1'b1;
            for (int unsigned r = 0; r < NUM_ROWS; r++) begin
                frame_d[key_index(col_q, 2'(r))] = ~row_sync[r];
            end
            // Last column closes the frame; compare the completed frame, not frame_q.
            if (col_q == 2'(NUM_COLS - 1)) begin
                prev_d = frame_d;
                if (frame_d == prev_q) begin
                    if (stable_cnt_q != CNT_MAX) stable_cnt_d = stable_cnt_q + 1'b1;
                    if (stable_cnt_d == CNT_MAX) key_map_d = frame_d;
                end else begin
                    stable_cnt_d = '0;
                end
                if (DEBOUNCE_CNT == 1) key_map_d = frame_d;
            end
        end

        if (valid_q && key_ready) valid_d = 1'b0;
        if (slot_free) begin
            if (press_cand != '0) begin
                code_d             = lowest_set(press_cand);
                valid_d            = 1'b1;
                reported_d[code_d] = 1'b1;
`ifdef KEYPAD_RELEASE_EVT_EN
                kind_d             = EVT_PRESS;
            end else if (rel_pend_d != '0) begin
                code_d             = lowest_set(rel_pend_d);
                valid_d            = 1'b1;
                kind_d             = EVT_RELEASE;
                rel_pend_d[code_d] = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            dwell_q      <= '0;
            col_q        <= '0;
            frame_q      <= '0;
            prev_q       <= '0;
            stable_cnt_q <= '0;
            key_map_q    <= '0;
            reported_q   <= '0;
            code_q       <= '0;
            valid_q      <= 1'b0;
`ifdef KEYPAD_RELEASE_EVT_EN
            rel_pend_q   <= '0;
            kind_q       <= EVT_PRESS;
`endif
        end else begin
            dwell_q      <= dwell_d;
            col_q        <= col_d;
            frame_q      <= frame_d;
            prev_q       <= prev_d;
            stable_cnt_q <= stable_cnt_d;
            key_map_q    <= key_map_d;
            reported_q   <= reported_d;
            code_q       <= code_d;
            valid_q      <= valid_d;
`ifdef KEYPAD_RELEASE_EVT_EN
            rel_pend_q   <= rel_pend_d;
            kind_q       <= kind_d;
`endif
        end
    end

    assign COL       = ~(4'b0001 << col_q);
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_map   = key_map_q;
`ifdef KEYPAD_RELEASE_EVT_EN
    assign key_release = (kind_q == EVT_RELEASE);
`else
    assign key_release = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scan_reader.sv
// Directed self-checking bench for keypad_scan_reader (SCAN_DIV=8, DEBOUNCE_CNT=3).
module tb_keypad_scan_reader;

    logic        clkin = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  COL;
    logic [3:0]  ROW;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready = 1'b0;
    logic [15:0] key_map;
    logic        key_release;
    logic [15:0] pressed = 16'h0000;

    int assert_count = 0;
    int fail_count   = 0;

    keypad_scan_reader #(.SCAN_DIV(8), .DEBOUNCE_CNT(3)) dut (
        .clkin       (clkin),
        .reset       (reset),
        .COL         (COL),
        .ROW         (ROW),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_map     (key_map),
        .key_release (key_release)
    );

    always #5 clkin = ~clkin;

    // Keypad matrix: a pressed key pulls its row low while its column is strobed.
    always_comb begin
        ROW = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (COL[c] == 1'b0) ROW = ROW & ~pressed[4*c +: 4];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("FAIL %s: got %0h, want %0h", tag, actual, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    task automatic wait_map(input logic [15:0] want, input int max_cycles);
        int n;
        n = 0;
        while (key_map !== want && n < max_cycles) begin
            step(1);
            n++;
        end
    endtask

    task automatic wait_valid(input int max_cycles);
        int n;
        n = 0;
        while (key_valid !== 1'b1 && n < max_cycles) begin
            step(1);
            n++;
        end
    endtask

    task automatic accept();
        key_ready = 1'b1;
        step(1);
        key_ready = 1'b0;
    endtask

    initial begin
        int rises;
        int n;
        int first_map;

        // Reset state and column strobe sequence
        step(5);
        check_eq("rst_col", COL, 4'b1110);
        check_eq("rst_valid", key_valid, 1'b0);
        check_eq("rst_map", key_map, 16'h0000);
        check_eq("rst_code", key_code, 4'h0);
        check_eq("rst_release", key_release, 1'b0);
        reset = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            step(1);
            if (i == 7)  check_eq("col_7", COL, 4'b1110);
            if (i == 8)  check_eq("col_8", COL, 4'b1101);
            if (i == 16) check_eq("col_16", COL, 4'b1011);
            if (i == 24) check_eq("col_24", COL, 4'b0111);
            if (i == 32) check_eq("col_32", COL, 4'b1110);
        end

        // Key 6 press, hold with ready low, single accept
        pressed = 16'h0040;
        wait_map(16'h0040, 200);
        check_eq("k6_map", key_map, 16'h0040);
        check_eq("k6_valid_lat0", key_valid, 1'b0);
        step(1);
        check_eq("k6_valid", key_valid, 1'b1);
        check_eq("k6_code", key_code, 4'd6);
        check_eq("k6_release_flag", key_release, 1'b0);
        step(10);
        check_eq("k6_hold_valid", key_valid, 1'b1);
        check_eq("k6_hold_code", key_code, 4'd6);
        accept();
        check_eq("k6_accept", key_valid, 1'b0);
        rises = 0;
        for (int i = 0; i < 64; i++) begin
            step(1);
            if (key_valid) rises++;
        end
        check_eq("k6_no_repeat", rises, 0);

        // Release key 6
        pressed = 16'h0000;
        wait_map(16'h0000, 200);
        check_eq("k6_rel_map", key_map, 16'h0000);
`ifdef KEYPAD_RELEASE_EVT_EN
        wait_valid(10);
        check_eq("k6_rel_valid", key_valid, 1'b1);
        check_eq("k6_rel_flag", key_release, 1'b1);
        check_eq("k6_rel_code", key_code, 4'd6);
        accept();
`endif
        step(4);
        check_eq("k6_rel_quiet", key_valid, 1'b0);

        // Re-press key 6: reported again
        pressed = 16'h0040;
        wait_valid(200);
        check_eq("k6_re_valid", key_valid, 1'b1);
        check_eq("k6_re_code", key_code, 4'd6);
        check_eq("k6_re_flag", key_release, 1'b0);
        accept();
        pressed = 16'h0000;
        wait_map(16'h0000, 200);
`ifdef KEYPAD_RELEASE_EVT_EN
        wait_valid(10);
        check_eq("k6_re_rel_flag", key_release, 1'b1);
        accept();
`endif
        step(8);

        // Bounce: key 6 on alternate frames
        for (int i = 0; i < 6; i++) begin
            pressed = (i % 2 == 0) ? 16'h0040 : 16'h0000;
            step(32);
            check_eq("bounce_map", key_map, 16'h0000);
            check_eq("bounce_valid", key_valid, 1'b0);
        end
        pressed = 16'h0000;
        step(100);
        check_eq("bounce_settle", key_valid, 1'b0);

        // Keys 3 and 12 together, ready held high: ascending back-to-back
        key_ready = 1'b1;
        pressed = 16'h1008;
        wait_valid(300);
        check_eq("dual_map", key_map, 16'h1008);
        check_eq("dual_first_valid", key_valid, 1'b1);
        check_eq("dual_first_code", key_code, 4'd3);
        step(1);
        check_eq("dual_second_valid", key_valid, 1'b1);
        check_eq("dual_second_code", key_code, 4'd12);
        step(1);
        check_eq("dual_drain", key_valid, 1'b0);
        pressed = 16'h0000;
        wait_map(16'h0000, 200);
`ifdef KEYPAD_RELEASE_EVT_EN
        wait_valid(10);
        check_eq("dual_rel1_flag", key_release, 1'b1);
        check_eq("dual_rel1_code", key_code, 4'd3);
        step(1);
        check_eq("dual_rel2_flag", key_release, 1'b1);
        check_eq("dual_rel2_code", key_code, 4'd12);
        step(1);
        check_eq("dual_rel_drain", key_valid, 1'b0);
`endif
        key_ready = 1'b0;
        step(8);

        // Reset pulse with a pending event, key still held
        pressed = 16'h0040;
        wait_valid(200);
        check_eq("rp_pre_valid", key_valid, 1'b1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_eq("rp_valid", key_valid, 1'b0);
        check_eq("rp_map", key_map, 16'h0000);
        check_eq("rp_col", COL, 4'b1110);
        n = 0;
        first_map = -1;
        while (key_valid !== 1'b1 && n < 200) begin
            step(1);
            n++;
            if (key_map != 16'h0000 && first_map < 0) first_map = n;
        end
        check_eq("rp_map_latency", first_map, 96);
        check_eq("rp_evt_latency", n, 97);
        check_eq("rp_code", key_code, 4'd6);
        accept();
        check_eq("rp_accept", key_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
